// File: rtl/imm_pkg.sv
// Shared constants for the RV32I immediate generator: format codes, base-ISA
// opcodes and the opcode-to-format classifier used by both pipeline variants.
package imm_pkg;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SH  = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Shift-immediate ops (slli/srli/srai) carry a shamt, not a signed immediate.
  function automatic logic [2:0] decode_fmt(input logic [6:0] opcode,
                                            input logic [2:0] funct3);
    logic [2:0] fmt;
    fmt = FMT_ILL;
    case (opcode)
      OPC_LOAD, OPC_MISC_MEM, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
      OPC_OP_IMM: fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
      OPC_STORE:             fmt = FMT_S;
      OPC_BRANCH:            fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:    fmt = FMT_U;
      OPC_JAL:               fmt = FMT_J;
      OPC_OP:                fmt = FMT_R;
      default:               fmt = FMT_ILL;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decoder: classifies the opcode and assembles
// the immediate, sign-extended (or zero-extended for shamt) to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic signed [31:0] imm32;

  assign fmt     = decode_fmt(inst[6:0], inst[14:12]);
  assign illegal = (fmt == FMT_ILL);

  // Build a 32-bit signed immediate, then widen; the signed cast does the
  // XLEN=64 sign fill without a zero-width replication at XLEN=32.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:  imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_SH: begin
        if (XLEN == 64) imm32 = {26'b0, inst[25:20]};
        else            imm32 = {27'b0, inst[24:20]};
      end
      FMT_S:  imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:  imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:  imm32 = {inst[31:12], 12'b0};
      FMT_J:  imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with valid/ready on both sides, synchronous
// flush and a 1- or 2-stage pipeline. The output stage is shared; the
// generate block supplies the entry presented to it.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  logic [2:0]       out_fmt_q,   out_fmt_d;
  logic             out_ill_q,   out_ill_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;

  logic             ready_out;
  logic             pipe_valid;
  logic [XLEN-1:0]  pipe_imm;
  logic [2:0]       pipe_fmt;
  logic             pipe_ill;
  logic [TAG_W-1:0] pipe_tag;

  assign ready_out = !out_valid_q || out_ready;

  generate
    if (STAGES == 1) begin : g_one
      logic [2:0]      dec_fmt;
      logic [XLEN-1:0] dec_imm;
      logic            dec_ill;

      imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (in_inst),
        .fmt     (dec_fmt),
        .imm     (dec_imm),
        .illegal (dec_ill)
      );

      // in_ready already excludes flush, so no entry is loaded in a flush cycle.
      assign in_ready   = ready_out && !flush;
      assign pipe_valid = in_valid && in_ready;
      assign pipe_imm   = dec_imm;
      assign pipe_fmt   = dec_fmt;
      assign pipe_ill   = dec_ill;
      assign pipe_tag   = in_tag;
    end else begin : g_two
      logic             s1_valid_q, s1_valid_d;
      logic [31:0]      s1_inst_q,  s1_inst_d;
      logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
      logic [2:0]       s1_fmt_q,   s1_fmt_d;
      logic             ready_s1;
      logic             in_load;
      logic [2:0]       dec_fmt;
      logic [XLEN-1:0]  dec_imm;
      logic             dec_ill;
      logic             unused_dec_bits;

      assign ready_s1 = !s1_valid_q || ready_out;
      assign in_ready = ready_s1 && !flush;
      assign in_load  = in_valid && in_ready;

      // Stage 1 next state: refill on accept, empty when handed to stage 2.
      always_comb begin
        s1_valid_d = s1_valid_q;
        s1_inst_d  = s1_inst_q;
        s1_tag_d   = s1_tag_q;
        s1_fmt_d   = s1_fmt_q;
        if (in_load) begin
          s1_valid_d = 1'b1;
          s1_inst_d  = in_inst;
          s1_tag_d   = in_tag;
          s1_fmt_d   = decode_fmt(in_inst[6:0], in_inst[14:12]);
        end else if (ready_out) begin
          s1_valid_d = 1'b0;
        end
        if (flush) s1_valid_d = 1'b0;
      end

      // Stage 1 register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid_q <= 1'b0;
          s1_inst_q  <= '0;
          s1_tag_q   <= '0;
          s1_fmt_q   <= FMT_R;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_inst_q  <= s1_inst_d;
          s1_tag_q   <= s1_tag_d;
          s1_fmt_q   <= s1_fmt_d;
        end
      end

      imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (s1_inst_q),
        .fmt     (dec_fmt),
        .imm     (dec_imm),
        .illegal (dec_ill)
      );

      // Format was already classified in stage 1; only the immediate is new here.
      assign unused_dec_bits = ^{dec_fmt, dec_ill};

      assign pipe_valid = s1_valid_q && !flush;
      assign pipe_imm   = dec_imm;
      assign pipe_fmt   = s1_fmt_q;
      assign pipe_ill   = (s1_fmt_q == FMT_ILL);
      assign pipe_tag   = s1_tag_q;
    end
  endgenerate

  // Output stage next state: load on transfer, drain on out_ready, hold otherwise.
  always_comb begin
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_fmt_d   = out_fmt_q;
    out_ill_d   = out_ill_q;
    out_tag_d   = out_tag_q;
    if (pipe_valid && ready_out) begin
      out_valid_d = 1'b1;
      out_imm_d   = pipe_imm;
      out_fmt_d   = pipe_fmt;
      out_ill_d   = pipe_ill;
      out_tag_d   = pipe_tag;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush) out_valid_d = 1'b0;
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_fmt_q   <= FMT_R;
      out_ill_q   <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_fmt_q   <= out_fmt_d;
      out_ill_q   <= out_ill_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;
  assign out_tag     = out_tag_q;

endmodule
